byte_fetch_ctrl: RTL
====================

BYTE_FETCH_CTRL -- requirements
Module: byte_fetch_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- init  in  1  slice-start pulse
- bs_data  in  8  bitstream byte
- bs_valid  in  1  byte available
- bs_ready  out  1  byte consumed this cycle
- req_valid  in  1  decode step request
- req_ready  out  1  request accepted when high with req_valid
- req_mode  in  1  0=regular, 1=bypass
- req_bits  in  3  regular: renorm shift 0..7; bypass: bin count 1..4
- out_valid  out  1  step result valid
- load_flag  out  1  byte inserted this step
- byte_out  out  8  inserted byte, 0 when load_flag=0
- bits_needed  out  4  signed shift amount for byte insertion
- bits_sel  out  4  signed bypass slot select (-1..-4 = EP0..EP3), 0 otherwise
- init_data  out  16  first two slice bytes, MSB first
- init_done  out  1  one-cycle pulse, init_data valid
- err  out  1  sticky illegal-request flag

Function
REQ-003 FSM states SHALL be IDLE, INIT0, INIT1 and RUN.
REQ-004 init=1 in any state SHALL force INIT0 next cycle, set bn=-8, clear err and drop nothing else in flight; req_ready SHALL be 0 while init=1.
REQ-005 INIT0/INIT1 behaviour:
- bs_ready=bs_valid.
- INIT0 captures init_data[15:8], then goes to INIT1.
- INIT1 captures init_data[7:0], then goes to RUN.
- init_done SHALL pulse in the cycle after the INIT1 capture.
REQ-006 Internal signed counter bn SHALL hold -8..-1 in RUN; n=req_bits; bn_new=bn+n (5-bit signed arithmetic); need=(bn_new>=0).
REQ-007 In RUN, req_ready=(!need || bs_valid) && !init; in all other states req_ready=0.
REQ-008 bs_ready SHALL be req_valid && req_ready && need in RUN (combinational); the byte SHALL be consumed in that same cycle.
REQ-009 On acceptance, outputs SHALL be registered and valid one cycle later (out_valid=1 for exactly one cycle per accepted request):
- load_flag=need.
- byte_out=need ? bs_data : 0.
- bits_needed=need ? bn_new : bn_new (unchanged value, informational).
- bits_sel=(need && bypass) ? bn : 0.
REQ-010 bn update on acceptance: bn <= need ? bn_new-8 : bn_new.
REQ-011 Regular n=0 SHALL be accepted with no load, bn unchanged and out_valid still pulsed.
REQ-012 Bypass n=0 or n>4 SHALL be accepted as a no-op (bn unchanged, load_flag=0, out_valid=1) and SHALL set err.
REQ-013 Throughput SHALL be one request per cycle when no stall occurs; at most one byte SHALL be fetched per request.
REQ-014 A stall (need && !bs_valid) SHALL hold req_ready=0; request inputs SHALL be re-evaluated every cycle (no latching before acceptance).
REQ-015 In IDLE, requests SHALL NOT be accepted (req_ready=0, bs_ready=0).

Reset
REQ-016 rst_n=0 SHALL immediately set:
- state=IDLE, bn=-8.
- out_valid, load_flag, init_done and err = 0.
- byte_out, bits_needed, bits_sel and init_data = 0.
REQ-017 Reset mid-operation SHALL discard any pending result; bs_ready and req_ready SHALL be 0 during reset.

Configuration
REQ-018 Macro BYTE_FETCH_CTRL_STALL_CNT_EN:
- Defined: adds output stall_cnt[15:0], incremented each RUN cycle with req_valid && need && !bs_valid; it saturates at 0xFFFF and is cleared by rst_n or init.
- Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Init with bytes 0xA5 then 0x3C -> init_done pulse, init_data=0xA53C, bn=-8.
- After init, regular n=3, 3, 2 -> third step load_flag=1, bits_needed=0, bn returns to -8.
- bn=-2, bypass n=4, byte 0x7E -> load_flag=1, bits_sel=-2, byte_out=0x7E, bn=-6.
- bn=-1, regular n=7, bs_valid low for 3 cycles -> req_ready=0 for 3 cycles; the byte is then consumed, bits_needed=6, bn=-2, stall_cnt=3 (macro on).
- Bypass n=5 -> out_valid=1, load_flag=0, err=1; a subsequent init clears err.
- rst_n asserted while stalled -> all outputs 0, state IDLE, and no request is accepted until init completes.

Source files
------------

// File: rtl/byte_fetch_ctrl.sv
// byte_fetch_ctrl: bitstream byte fetch controller for an arithmetic decoder.
// Tracks a signed bit counter bn (-8..-1) and inserts one bitstream byte
// whenever a regular renorm shift or bypass bin read crosses a byte boundary.
// Optional feature macro: BYTE_FETCH_CTRL_STALL_CNT_EN adds a 16-bit
// saturating stall counter output (stall_cnt).
module byte_fetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic [7:0]  bs_data,
    input  logic        bs_valid,
    output logic        bs_ready,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [2:0]  req_bits,
    output logic        out_valid,
    output logic        load_flag,
    output logic [7:0]  byte_out,
    output logic [3:0]  bits_needed,
    output logic [3:0]  bits_sel,
    output logic [15:0] init_data,
    output logic        init_done,
    output logic        err
`ifdef BYTE_FETCH_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned BN_W   = 4;
    localparam int unsigned EXT_W  = 5;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned INIT_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BN_W-1:0] BN_RESET = BN_W'(4'b1000);  // -8

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT0 = 2'd1,
        S_INIT1 = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BN_W-1:0]     bn_q, bn_d;
    logic                out_valid_q, out_valid_d;
    logic                load_flag_q, load_flag_d;
    logic [BYTE_W-1:0]   byte_out_q, byte_out_d;
    logic [BN_W-1:0]     bits_needed_q, bits_needed_d;
    logic [BN_W-1:0]     bits_sel_q, bits_sel_d;
    logic [INIT_W-1:0]   init_data_q, init_data_d;
    logic                init_done_q, init_done_d;
    logic                err_q, err_d;

    logic [EXT_W-1:0]    bn_ext;
    logic [EXT_W-1:0]    n_ext;
    logic [EXT_W-1:0]    bn_new;
    logic                byp_illegal;
    logic                need;
    logic                in_run;
    logic                accept;

    // Step arithmetic: bn_new = bn + n in 5-bit signed; a byte is needed once it goes non-negative
    always_comb begin
        bn_ext      = {bn_q[BN_W-1], bn_q};
        n_ext       = EXT_W'(req_bits);
        bn_new      = bn_ext + n_ext;
        byp_illegal = req_mode && ((req_bits == 3'd0) || (req_bits > 3'd4));
        need        = !byp_illegal && !bn_new[EXT_W-1];
        in_run      = (state_q == S_RUN);
    end

    // Handshakes are combinational so a byte is consumed in the accepting cycle
    always_comb begin
        req_ready = in_run && (!need || bs_valid) && !init;
        accept    = req_valid && req_ready;
        bs_ready  = 1'b0;
        unique case (state_q)
            S_INIT0, S_INIT1: bs_ready = bs_valid && !init;
            S_RUN:            bs_ready = accept && need;
            default:          bs_ready = 1'b0;
        endcase
    end

    // Next-state and registered-output logic; init overrides every state
    always_comb begin
        state_d       = state_q;
        bn_d          = bn_q;
        out_valid_d   = 1'b0;
        load_flag_d   = load_flag_q;
        byte_out_d    = byte_out_q;
        bits_needed_d = bits_needed_q;
        bits_sel_d    = bits_sel_q;
        init_data_d   = init_data_q;
        init_done_d   = 1'b0;
        err_d         = err_q;

        if (init) begin
            state_d = S_INIT0;
            bn_d    = BN_RESET;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_INIT0: begin
                    if (bs_valid) begin
                        init_data_d[15:8] = bs_data;
                        state_d           = S_INIT1;
                    end
                end
                S_INIT1: begin
                    if (bs_valid) begin
                        init_data_d[7:0] = bs_data;
                        state_d          = S_RUN;
                        init_done_d      = 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        out_valid_d   = 1'b1;
                        load_flag_d   = need;
                        byte_out_d    = need ? bs_data : BYTE_W'(0);
                        bits_needed_d = bn_new[BN_W-1:0];
                        bits_sel_d    = (need && req_mode) ? bn_q : BN_W'(0);
                        if (byp_illegal) begin
                            // Illegal bypass count is a no-op apart from the sticky error
                            err_d = 1'b1;
                        end else if (need) begin
                            bn_d = BN_W'(bn_new - EXT_W'(8));
                        end else begin
                            bn_d = bn_new[BN_W-1:0];
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bn_q          <= BN_RESET;
            out_valid_q   <= 1'b0;
            load_flag_q   <= 1'b0;
            byte_out_q    <= '0;
            bits_needed_q <= '0;
            bits_sel_q    <= '0;
            init_data_q   <= '0;
            init_done_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bn_q          <= bn_d;
            out_valid_q   <= out_valid_d;
            load_flag_q   <= load_flag_d;
            byte_out_q    <= byte_out_d;
            bits_needed_q <= bits_needed_d;
            bits_sel_q    <= bits_sel_d;
            init_data_q   <= init_data_d;
            init_done_q   <= init_done_d;
            err_q         <= err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign load_flag   = load_flag_q;
    assign byte_out    = byte_out_q;
    assign bits_needed = bits_needed_q;
    assign bits_sel    = bits_sel_q;
    assign init_data   = init_data_q;
    assign init_done   = init_done_q;
    assign err         = err_q;

`ifdef BYTE_FETCH_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of RUN cycles where a pending request waits for a byte
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (init) begin
            stall_cnt_d = '0;
        end else if (in_run && req_valid && need && !bs_valid &&
                     (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
